cmp_iter_lsb: RTL

//  Multi-cycle magnitude comparator that scans operands LSB-chunk first, CHUNK bits per cycle.

---
 rtl/cmp_iter_lsb_pkg.sv | 22 ++
 rtl/cmp_iter_lsb_chunk.sv | 13 +
 rtl/cmp_iter_lsb.sv | 105 ++++++++++
 3 files changed

// File: rtl/cmp_iter_lsb_pkg.sv
// Shared result codes, FSM state encoding and the code-forming helper for the
// iterative comparator and the single-cycle compare it replaces.
package cmp_iter_lsb_pkg;

  localparam logic [1:0] OP1_GT_OP2 = 2'b01;
  localparam logic [1:0] OP1_LT_OP2 = 2'b10;
  localparam logic [1:0] OP1_EQ_OP2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Collapse a greater/less pair into the 2-bit result code.
  function automatic logic [1:0] cmp_code(input logic gt, input logic lt);
    if (gt)      return OP1_GT_OP2;
    else if (lt) return OP1_LT_OP2;
    else         return OP1_EQ_OP2;
  endfunction

endpackage

// File: rtl/cmp_iter_lsb_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare returning the 2-bit code.
module cmp_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic [1:0]       o_res_c
);
  import cmp_iter_lsb_pkg::*;

  assign o_res_c = cmp_code(i_a > i_b, i_a < i_b);

endmodule

// File: rtl/cmp_iter_lsb.sv
// Multi-cycle magnitude comparator: scans operands LSB chunk first, CHUNK bits
// per cycle, with valid/ready on both sides and an optional signed mode.
module cmp_iter_lsb #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       res
);
  import cmp_iter_lsb_pkg::*;

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
  localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);

  if (((WIDTH % CHUNK) != 0) || ((WIDTH / CHUNK) < 2)) begin : g_bad_params
    $error("cmp_iter_lsb: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic             r_is_signed;
  logic [1:0]       r_acc;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_flip;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [1:0]       w_chunk_res;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  // Flipping the sign bit of the top chunk maps two's-complement order onto unsigned order.
  assign w_flip = r_is_signed && w_last;
  assign w_a    = CHUNK'(r_op1 >> (32'(r_cnt) * CHUNK)) ^ (w_flip ? SIGN_MASK : '0);
  assign w_b    = CHUNK'(r_op2 >> (32'(r_cnt) * CHUNK)) ^ (w_flip ? SIGN_MASK : '0);

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .i_a     (w_a),
    .i_b     (w_b),
    .o_res_c (w_chunk_res)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Higher chunks are visited later, so any unequal chunk simply overwrites acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_is_signed <= 1'b0;
      r_acc       <= OP1_EQ_OP2;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_op1       <= op1;
        r_op2       <= op2;
        r_is_signed <= is_signed;
        r_cnt       <= '0;
        r_acc       <= OP1_EQ_OP2;
      end else if (r_state == ST_RUN) begin
        if (w_chunk_res != OP1_EQ_OP2) r_acc <= w_chunk_res;
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_acc;

endmodule
